perf_event_counters: RTL

//   Synthesizable bank of NUM_EVENTS event counters for processor performance monitoring.

---
 rtl/perf_event_counters.sv | 85 ++++++++
 1 files changed

// File: rtl/perf_event_counters.sv
// Bank of NUM_EVENTS free-running event counters with freeze-on-halt and a registered read port.
// Build option: define PERF_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module perf_event_counters #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [NUM_EVENTS-1:0] event_vld,
    input  logic                  halt,
    input  logic                  rd_req,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic                  rd_ack,
    output logic [CNT_W-1:0]      rd_data,
    output logic [NUM_EVENTS-1:0] ovf,
    output logic                  frozen
);

    logic [CNT_W-1:0] cnt [NUM_EVENTS];
    logic [CNT_W-1:0] rd_mux;
    logic             cnt_en;

    assign cnt_en = en & ~frozen;

    // clr wins over events and halt; halt still lets this cycle's events count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt[i] <= '0;
            end
            ovf    <= '0;
            frozen <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt[i] <= '0;
            end
            ovf    <= '0;
            frozen <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (event_vld[i] && cnt_en) begin
                    if (cnt[i] == {CNT_W{1'b1}}) begin
                        ovf[i] <= 1'b1;
`ifndef PERF_SATURATE_EN
                        cnt[i] <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
            if (halt) begin
                frozen <= 1'b1;
            end
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux = cnt[i];
            end
        end
    end

    // Read handshake: rd_req sampled at edge N (no backpressure) yields a one-cycle rd_ack
    // after edge N with rd_data = counter value held before edge N; rd_data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule
